fix_session_scheduler: RTL and testbench

// - Sequences outbound FIX session traffic. Owns heartbeat/test-request timing and arbitrates

---
 rtl/fix_session_scheduler_pkg.sv | 43 ++++
 rtl/fix_session_scheduler_if.sv | 24 ++
 rtl/fix_session_scheduler_idle_timer.sv | 30 +++
 rtl/fix_session_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_fix_session_scheduler.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fix_session_scheduler_pkg.sv
// Shared types for the FIX session scheduler: message codes, FSM states and
// the internal grant identifiers used by the arbiter.
package fix_pkg;

  typedef enum logic [2:0] {
    MT_NONE      = 3'b000,
    MT_LOGON     = 3'b001,
    MT_HEARTBEAT = 3'b010,
    MT_TESTREQ   = 3'b011,
    MT_LOGOUT    = 3'b100,
    MT_APP       = 3'b101
  } msg_type_t;

  typedef logic [1:0] sched_state_t;
  localparam sched_state_t S_IDLE  = 2'd0;
  localparam sched_state_t S_OFFER = 2'd1;
  localparam sched_state_t S_BUSY  = 2'd2;

  // Heartbeat and heartbeat-response share MT_HEARTBEAT, so the winner is
  // tracked separately to know which pending flag an accept retires.
  typedef enum logic [2:0] {
    G_NONE,
    G_LOGOUT,
    G_HB_RSP,
    G_TESTREQ,
    G_HB,
    G_LOGON,
    G_APP
  } grant_t;

  function automatic msg_type_t grant_msg(input grant_t g);
    case (g)
      G_LOGOUT:  return MT_LOGOUT;
      G_HB_RSP:  return MT_HEARTBEAT;
      G_TESTREQ: return MT_TESTREQ;
      G_HB:      return MT_HEARTBEAT;
      G_LOGON:   return MT_LOGON;
      G_APP:     return MT_APP;
      default:   return MT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fix_session_scheduler_if.sv
// Offer/accept/done handshake between the scheduler and the message generator.
interface fix_session_scheduler_if;
  import fix_pkg::*;

  logic      send_valid;
  msg_type_t send_type;
  logic      send_ready;
  logic      send_done;

  modport master (
    output send_valid,
    output send_type,
    input  send_ready,
    input  send_done
  );

  modport slave (
    input  send_valid,
    input  send_type,
    output send_ready,
    output send_done
  );

endinterface

// File: rtl/fix_session_scheduler_idle_timer.sv
// Saturating idle-tick counter with synchronous clear and an equality compare
// against a threshold one bit wider than the counter.
module fix_idle_timer #(
  parameter int TICK_W = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            tick,
  input  logic            clr,
  input  logic [TICK_W:0] cmp,
  output logic            hit
);

  logic [TICK_W-1:0] cnt;

  // Clear dominates a coincident tick; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && tick && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = run && ({1'b0, cnt} == cmp);

endmodule

// File: rtl/fix_session_scheduler.sv
// Outbound FIX session sequencer: heartbeat / test-request timing, peer timeout
// and fixed-priority arbitration of session and application sends.
module fix_session_scheduler
  import fix_pkg::*;
#(
  parameter int TICK_W      = 9,
  parameter int GRACE_TICKS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      logged_on_i,
  input  logic [7:0]                heartBeatInt_i,
  input  logic                      tick_i,
  input  logic                      logon_req_i,
  input  logic                      logout_req_i,
  input  logic                      app_req_i,
  input  logic                      new_message_r_i,
  input  logic [2:0]                received_msg_type_i,
  fix_session_scheduler_if.master   send_if,
  output logic                      disconnect_o
);

  localparam int CMP_W = TICK_W + 1;

  sched_state_t state;
  grant_t       grant;
  grant_t       win;

  logic p_logon, p_logout, p_hb_rsp, p_testreq, p_hb;
  logic n_logon, n_logout, n_hb_rsp, n_testreq, n_hb;
  logic testreq_out;
  logic logout_sent;
  logic logged_on_q;

  logic timers_run, logon_fall, accept;
  logic tx_hit, rx_hit, tx_clr, rx_clr;
  logic tr_evt, dc_evt;
  logic inbound_testreq, inbound_logout;
  logic [CMP_W-1:0] tx_cmp, rx_cmp, rx_first, rx_second;

  // A drop (timeout or session loss) beats a set, and a set beats a grant clear.
  function automatic logic flag_nxt(input logic cur, input logic set,
                                    input logic clr, input logic drop);
    if (drop) return 1'b0;
    if (set)  return 1'b1;
    if (clr)  return 1'b0;
    return cur;
  endfunction

  assign timers_run = logged_on_i && (heartBeatInt_i != 8'd0);
  assign logon_fall = logged_on_q && !logged_on_i;
  assign accept     = (state == S_OFFER) && send_if.send_ready;

  assign tx_cmp    = CMP_W'(heartBeatInt_i);
  assign rx_first  = CMP_W'(heartBeatInt_i) + CMP_W'(GRACE_TICKS);
  assign rx_second = CMP_W'({heartBeatInt_i, 1'b0}) + CMP_W'(GRACE_TICKS);
  // One comparator serves both rx thresholds: the outstanding flag picks which.
  assign rx_cmp    = testreq_out ? rx_second : rx_first;

  // Any inbound traffic proves the peer alive, so it also suppresses rx events.
  assign tr_evt = rx_hit && !testreq_out && !new_message_r_i;
  assign dc_evt = rx_hit &&  testreq_out && !new_message_r_i;

  assign tx_clr = accept || tx_hit || dc_evt || !logged_on_i;
  assign rx_clr = new_message_r_i || dc_evt || !logged_on_i;

  assign inbound_testreq = new_message_r_i && (received_msg_type_i == MT_TESTREQ);
  assign inbound_logout  = new_message_r_i && (received_msg_type_i == MT_LOGOUT);

  fix_idle_timer #(.TICK_W(TICK_W)) u_tx_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (timers_run),
    .tick (tick_i),
    .clr  (tx_clr),
    .cmp  (tx_cmp),
    .hit  (tx_hit)
  );

  fix_idle_timer #(.TICK_W(TICK_W)) u_rx_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (timers_run),
    .tick (tick_i),
    .clr  (rx_clr),
    .cmp  (rx_cmp),
    .hit  (rx_hit)
  );

  always_comb begin
    n_logout  = flag_nxt(p_logout,
                         logout_req_i || (inbound_logout && !logout_sent),
                         accept && (grant == G_LOGOUT), 1'b0);
    n_hb_rsp  = flag_nxt(p_hb_rsp, inbound_testreq,
                         accept && (grant == G_HB_RSP), dc_evt || logon_fall);
    n_testreq = flag_nxt(p_testreq, tr_evt,
                         accept && (grant == G_TESTREQ), dc_evt || logon_fall);
    n_hb      = flag_nxt(p_hb, tx_hit,
                         accept && (grant == G_HB), dc_evt || logon_fall);
    n_logon   = flag_nxt(p_logon, logon_req_i && !logged_on_i,
                         accept && (grant == G_LOGON), dc_evt);
  end

  // Arbitrating on next-state flags gives a one-cycle request-to-offer latency.
  always_comb begin
    win = G_NONE;
    if (n_logout)                        win = G_LOGOUT;
    else if (n_hb_rsp)                   win = G_HB_RSP;
    else if (n_testreq)                  win = G_TESTREQ;
    else if (n_hb)                       win = G_HB;
    else if (n_logon && !logged_on_i)    win = G_LOGON;
    else if (app_req_i && logged_on_i)   win = G_APP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_logon     <= 1'b0;
      p_logout    <= 1'b0;
      p_hb_rsp    <= 1'b0;
      p_testreq   <= 1'b0;
      p_hb        <= 1'b0;
      testreq_out <= 1'b0;
      logout_sent <= 1'b0;
      logged_on_q <= 1'b0;
      disconnect_o <= 1'b0;
    end else begin
      p_logon     <= n_logon;
      p_logout    <= n_logout;
      p_hb_rsp    <= n_hb_rsp;
      p_testreq   <= n_testreq;
      p_hb        <= n_hb;
      logged_on_q <= logged_on_i;
      disconnect_o <= dc_evt;
      if (new_message_r_i || dc_evt || !logged_on_i) begin
        testreq_out <= 1'b0;
      end else if (tr_evt) begin
        testreq_out <= 1'b1;
      end
      // Remember our own Logout so the peer's acknowledgement is not answered.
      if (accept && (grant == G_LOGOUT)) begin
        logout_sent <= 1'b1;
      end else if (accept && (grant == G_LOGON)) begin
        logout_sent <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      grant              <= G_NONE;
      send_if.send_valid <= 1'b0;
      send_if.send_type  <= MT_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (win != G_NONE) begin
            state              <= S_OFFER;
            grant              <= win;
            send_if.send_valid <= 1'b1;
            send_if.send_type  <= grant_msg(win);
          end
        end
        S_OFFER: begin
          if (send_if.send_ready) begin
            state              <= S_BUSY;
            send_if.send_valid <= 1'b0;
          end
        end
        S_BUSY: begin
          // Returning to idle here leaves a one-cycle gap before the next offer.
          if (send_if.send_done) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state              <= S_IDLE;
          send_if.send_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fix_session_scheduler.sv
// Directed bench for fix_session_scheduler with a small generator model that
// accepts offers and returns send_done two cycles after each accept.
module tb_fix_session_scheduler;
  import fix_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       logged_on;
  logic [7:0] hb_int;
  logic       tick;
  logic       logon_req;
  logic       logout_req;
  logic       app_req;
  logic       new_msg;
  logic [2:0] msg_type;
  logic       disconnect;

  int tests = 0;
  int fails = 0;
  int dc_count = 0;
  logic [2:0] acc_log[$];

  fix_session_scheduler_if sif ();

  fix_session_scheduler #(.TICK_W(9), .GRACE_TICKS(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .logged_on_i         (logged_on),
    .heartBeatInt_i      (hb_int),
    .tick_i              (tick),
    .logon_req_i         (logon_req),
    .logout_req_i        (logout_req),
    .app_req_i           (app_req),
    .new_message_r_i     (new_msg),
    .received_msg_type_i (msg_type),
    .send_if             (sif),
    .disconnect_o        (disconnect)
  );

  always #5 clk = ~clk;

  // Generator model: log each accepted type, pulse done two cycles later.
  initial begin
    sif.send_done = 1'b0;
    forever begin
      @(negedge clk);
      if (sif.send_valid === 1'b1 && sif.send_ready === 1'b1 && rst === 1'b0) begin
        acc_log.push_back(sif.send_type);
        @(posedge clk);
        @(posedge clk);
        #1 sif.send_done = 1'b1;
        @(posedge clk);
        #1 sif.send_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (disconnect === 1'b1) dc_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One-cycle tick, optionally with a coincident inbound app message.
  task automatic do_tick(input logic with_msg);
    tick = 1'b1;
    new_msg = with_msg;
    msg_type = MT_APP;
    step();
    tick = 1'b0;
    new_msg = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  int base;
  int dc_base;

  initial begin
    rst = 1'b1; logged_on = 1'b0; hb_int = 8'd0; tick = 1'b0;
    logon_req = 1'b0; logout_req = 1'b0; app_req = 1'b0;
    new_msg = 1'b0; msg_type = MT_NONE; sif.send_ready = 1'b0;
    idle(3);
    chk("reset_valid", 32'(sif.send_valid), 32'd0);
    chk("reset_type", 32'(sif.send_type), 32'(MT_NONE));
    chk("reset_disc", 32'(disconnect), 32'd0);
    rst = 1'b0;

    // Heartbeat every 3 ticks; rx traffic keeps the peer alive.
    logged_on = 1'b1; hb_int = 8'd3; sif.send_ready = 1'b1;
    idle(2);
    base = acc_log.size();
    do_tick(1'b1); idle(7);
    do_tick(1'b1); idle(7);
    chk("hb_none_before_t3", 32'(acc_log.size() - base), 32'd0);
    do_tick(1'b1);
    chk("hb_hit_cycle_no_valid", 32'(sif.send_valid), 32'd0);
    step();
    chk("hb_valid_after_t3", 32'(sif.send_valid), 32'd1);
    chk("hb_type_after_t3", 32'(sif.send_type), 32'(MT_HEARTBEAT));
    idle(6);
    do_tick(1'b1); idle(7);
    do_tick(1'b1); idle(7);
    chk("hb_count_t5", 32'(acc_log.size() - base), 32'd1);
    do_tick(1'b1); idle(7);
    chk("hb_count_t6", 32'(acc_log.size() - base), 32'd2);
    chk("hb_repeat_type", 32'(acc_log[base + 1]), 32'(MT_HEARTBEAT));

    // Silent peer: TestRequest after tick 5, disconnect after tick 8.
    do_reset();
    base = acc_log.size();
    dc_base = dc_count;
    for (int t = 1; t <= 4; t++) begin
      do_tick(1'b0); idle(7);
    end
    do_tick(1'b0);
    step();
    chk("tr_valid_after_t5", 32'(sif.send_valid), 32'd1);
    chk("tr_type_after_t5", 32'(sif.send_type), 32'(MT_TESTREQ));
    idle(6);
    do_tick(1'b0); idle(7);
    do_tick(1'b0); idle(7);
    chk("dc_none_before_t8", 32'(dc_count - dc_base), 32'd0);
    do_tick(1'b0);
    chk("dc_not_yet", 32'(disconnect), 32'd0);
    step();
    chk("dc_pulse", 32'(disconnect), 32'd1);
    chk("dc_no_hb_offer", 32'(sif.send_valid), 32'd0);
    step();
    chk("dc_pulse_end", 32'(disconnect), 32'd0);
    idle(6);
    chk("dc_once", 32'(dc_count - dc_base), 32'd1);
    chk("dc_log_size", 32'(acc_log.size() - base), 32'd2);
    chk("dc_log0", 32'(acc_log[base]), 32'(MT_HEARTBEAT));
    chk("dc_log1", 32'(acc_log[base + 1]), 32'(MT_TESTREQ));

    // Peer answers at tick 6: no disconnect, rx count restarts.
    do_reset();
    base = acc_log.size();
    dc_base = dc_count;
    for (int t = 1; t <= 5; t++) begin
      do_tick(1'b0); idle(7);
    end
    do_tick(1'b1); idle(7);
    for (int t = 7; t <= 10; t++) begin
      do_tick(1'b0); idle(7);
    end
    chk("rx_no_dc", 32'(dc_count - dc_base), 32'd0);
    do_tick(1'b0);
    step();
    chk("rx_restart_tr_type", 32'(sif.send_type), 32'(MT_TESTREQ));
    idle(8);
    chk("rx_log_size", 32'(acc_log.size() - base), 32'd5);
    chk("rx_log3", 32'(acc_log[base + 3]), 32'(MT_TESTREQ));
    chk("rx_log4", 32'(acc_log[base + 4]), 32'(MT_HEARTBEAT));

    // Inbound TestRequest answered before the waiting application message.
    hb_int = 8'd0;
    do_reset();
    base = acc_log.size();
    app_req = 1'b1; new_msg = 1'b1; msg_type = MT_TESTREQ;
    step();
    new_msg = 1'b0; msg_type = MT_NONE;
    chk("hbrsp_type", 32'(sif.send_type), 32'(MT_HEARTBEAT));
    idle(6);
    app_req = 1'b0;
    idle(6);
    chk("hbrsp_first", 32'(acc_log[base]), 32'(MT_HEARTBEAT));
    chk("hbrsp_then_app", 32'(acc_log[base + 1]), 32'(MT_APP));

    // Logout and heartbeat together, generator stalled for 4 cycles.
    hb_int = 8'd3; sif.send_ready = 1'b0;
    do_reset();
    base = acc_log.size();
    do_tick(1'b1); idle(7);
    do_tick(1'b1); idle(7);
    do_tick(1'b1);
    logout_req = 1'b1;
    step();
    logout_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("stall_valid", 32'(sif.send_valid), 32'd1);
      chk("stall_type", 32'(sif.send_type), 32'(MT_LOGOUT));
      if (c < 3) step();
    end
    sif.send_ready = 1'b1;
    idle(10);
    chk("stall_log_size", 32'(acc_log.size() - base), 32'd2);
    chk("stall_log1_hb", 32'(acc_log[base + 1]), 32'(MT_HEARTBEAT));

    // Logon while logged out; no heartbeats without a session.
    logged_on = 1'b0; hb_int = 8'd0;
    do_reset();
    base = acc_log.size();
    logon_req = 1'b1;
    step();
    logon_req = 1'b0;
    chk("logon_valid", 32'(sif.send_valid), 32'd1);
    chk("logon_type", 32'(sif.send_type), 32'(MT_LOGON));
    idle(6);
    hb_int = 8'd3;
    for (int t = 0; t < 4; t++) begin
      do_tick(1'b0); idle(5);
    end
    chk("logon_single", 32'(acc_log.size() - base), 32'd1);
    logged_on = 1'b1; hb_int = 8'd0;
    idle(2);
    logon_req = 1'b1;
    step();
    logon_req = 1'b0;
    idle(6);
    chk("logon_ignored_logged_on", 32'(acc_log.size() - base), 32'd1);

    // Reset during an offer abandons it.
    sif.send_ready = 1'b0;
    logout_req = 1'b1;
    step();
    logout_req = 1'b0;
    chk("rst_offer_valid", 32'(sif.send_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_valid_cleared", 32'(sif.send_valid), 32'd0);
    chk("rst_type_cleared", 32'(sif.send_type), 32'(MT_NONE));
    idle(5);
    chk("rst_no_new_offer", 32'(sif.send_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
